// File: rtl/gcn_edge_aggregator.sv
// GCN edge aggregator: steers the FM·W row address from the current COO edge and
// accumulates fetched rows, with saturation, into a per-node A·FM·W memory.
module gcn_edge_aggregator #(
  parameter int COO_EDGES = 6,
  parameter int COO_BW    = $clog2(COO_EDGES),
  parameter int NODES     = 4,
  parameter int NODE_BW   = $clog2(NODES),
  parameter int FEATURES  = 3,
  parameter int DATA_W    = 16,
  parameter int ACC_W     = 20
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         clear,
  input  logic                         read_fm_wm_adj,
  input  logic                         read_fm_wm,
  input  logic                         enable_write_fm_wm_adj_prod,
  input  logic                         enable_edge_counter,
  input  logic [NODE_BW-1:0]           coo_src,
  input  logic [NODE_BW-1:0]           coo_dst,
  input  logic [FEATURES*DATA_W-1:0]   fm_wm_row,
  input  logic [NODE_BW-1:0]           rd_node,
  output logic [COO_BW-1:0]            edge_count,
  output logic [NODE_BW-1:0]           fm_wm_addr,
  output logic [FEATURES*ACC_W-1:0]    rd_data,
  output logic                         protocol_err
);

  logic [COO_BW-1:0]          edge_count_q, edge_count_d;
  logic                       err_q, err_d;
  logic [FEATURES*ACC_W-1:0]  rd_data_q, rd_data_d;
  logic signed [ACC_W-1:0]    acc_q [NODES][FEATURES];
  logic signed [ACC_W-1:0]    acc_d [NODES][FEATURES];

  logic [NODE_BW-1:0] target;
  logic [31:0]        target_wide;
  logic               wr_req, range_err, err_now, self_loop, do_write;

  function automatic logic signed [ACC_W-1:0] sat_add(
    input logic signed [ACC_W-1:0]  a,
    input logic signed [DATA_W-1:0] b
  );
    logic [ACC_W:0] s;
    s = {a[ACC_W-1], a} + {{(ACC_W+1-DATA_W){b[DATA_W-1]}}, b};
    // Sign bits disagree only on overflow; the carry-out bit gives the direction.
    if (s[ACC_W] != s[ACC_W-1])
      return s[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return s[ACC_W-1:0];
  endfunction

  always_comb begin
    fm_wm_addr  = read_fm_wm_adj ? coo_src : (read_fm_wm ? coo_dst : '0);
    target      = read_fm_wm_adj ? coo_dst : coo_src;
    target_wide = 32'(target);
    wr_req      = enable_write_fm_wm_adj_prod & (read_fm_wm_adj ^ read_fm_wm);
    range_err   = wr_req && (target_wide >= 32'(NODES));
    err_now     = (read_fm_wm_adj & read_fm_wm)
                | (enable_write_fm_wm_adj_prod & ~read_fm_wm_adj & ~read_fm_wm)
                | (enable_edge_counter & (read_fm_wm_adj | read_fm_wm | enable_write_fm_wm_adj_prod))
                | range_err;
    self_loop   = read_fm_wm & (coo_src == coo_dst);
    do_write    = wr_req & ~err_now & ~self_loop;
    err_d       = err_q | err_now;

    edge_count_d = edge_count_q;
    if (enable_edge_counter)
      edge_count_d = (edge_count_q == COO_BW'(COO_EDGES - 1)) ? '0 : edge_count_q + COO_BW'(1);

    acc_d     = acc_q;
    rd_data_d = '0;
    for (int unsigned n = 0; n < NODES; n++) begin
      for (int unsigned f = 0; f < FEATURES; f++) begin
        if (do_write && target == NODE_BW'(n))
          acc_d[n][f] = sat_add(acc_q[n][f], fm_wm_row[f*DATA_W +: DATA_W]);
        if (rd_node == NODE_BW'(n))
          rd_data_d[f*ACC_W +: ACC_W] = acc_q[n][f];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      edge_count_q <= '0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      for (int unsigned n = 0; n < NODES; n++)
        for (int unsigned f = 0; f < FEATURES; f++)
          acc_q[n][f] <= '0;
    end else if (clear) begin
      edge_count_q <= '0;
      err_q        <= 1'b0;
      rd_data_q    <= '0;
      for (int unsigned n = 0; n < NODES; n++)
        for (int unsigned f = 0; f < FEATURES; f++)
          acc_q[n][f] <= '0;
    end else begin
      edge_count_q <= edge_count_d;
      err_q        <= err_d;
      rd_data_q    <= rd_data_d;
      for (int unsigned n = 0; n < NODES; n++)
        for (int unsigned f = 0; f < FEATURES; f++)
          acc_q[n][f] <= acc_d[n][f];
    end
  end

  assign edge_count   = edge_count_q;
  assign protocol_err = err_q;
  assign rd_data      = rd_data_q;

endmodule

// File: tb/tb_gcn_edge_aggregator.sv
// Directed bench for gcn_edge_aggregator: a table of COO edges with hand-computed
// cumulative accumulators, plus saturation, protocol-error and mid-edge reset sequences.
module tb_gcn_edge_aggregator;

  localparam int COO_EDGES = 6;
  localparam int COO_BW    = 3;
  // Three nodes on a 2-bit index so that node 3 is a representable out-of-range index.
  localparam int NODES     = 3;
  localparam int NODE_BW   = 2;
  localparam int FEATURES  = 3;
  localparam int DATA_W    = 16;
  localparam int ACC_W     = 20;
  localparam int RW        = FEATURES*DATA_W;
  localparam int AW        = FEATURES*ACC_W;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic            clear = 1'b0;
  logic            read_fm_wm_adj = 1'b0;
  logic            read_fm_wm = 1'b0;
  logic            enable_write_fm_wm_adj_prod = 1'b0;
  logic            enable_edge_counter = 1'b0;
  logic [NODE_BW-1:0] coo_src = '0;
  logic [NODE_BW-1:0] coo_dst = '0;
  logic [RW-1:0]   fm_wm_row = '0;
  logic [NODE_BW-1:0] rd_node = '0;
  logic [COO_BW-1:0]  edge_count;
  logic [NODE_BW-1:0] fm_wm_addr;
  logic [AW-1:0]   rd_data;
  logic            protocol_err;

  int checks = 0;
  int failures = 0;

  gcn_edge_aggregator #(
    .COO_EDGES(COO_EDGES), .COO_BW(COO_BW), .NODES(NODES), .NODE_BW(NODE_BW),
    .FEATURES(FEATURES), .DATA_W(DATA_W), .ACC_W(ACC_W)
  ) dut (
    .clk(clk), .reset(reset), .clear(clear),
    .read_fm_wm_adj(read_fm_wm_adj), .read_fm_wm(read_fm_wm),
    .enable_write_fm_wm_adj_prod(enable_write_fm_wm_adj_prod),
    .enable_edge_counter(enable_edge_counter),
    .coo_src(coo_src), .coo_dst(coo_dst), .fm_wm_row(fm_wm_row), .rd_node(rd_node),
    .edge_count(edge_count), .fm_wm_addr(fm_wm_addr), .rd_data(rd_data),
    .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  function automatic logic [RW-1:0] row3(input int a, input int b, input int c);
    return {16'(c), 16'(b), 16'(a)};
  endfunction

  function automatic logic [AW-1:0] acc3(input int a, input int b, input int c);
    return {20'(c), 20'(b), 20'(a)};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    read_fm_wm_adj = 1'b0;
    read_fm_wm = 1'b0;
    enable_write_fm_wm_adj_prod = 1'b0;
    enable_edge_counter = 1'b0;
  endtask

  task automatic read_check(input string name, input int node, input logic [AW-1:0] exp);
    idle();
    rd_node = NODE_BW'(node);
    tick();
    check(name, 64'(rd_data), 64'(exp));
  endtask

  task automatic do_clear();
    idle();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  logic [RW-1:0] rows [NODES];

  // Full 5-cycle controller sequence for edge (src,dst); memory latency is modelled
  // by presenting the addressed row in the write cycle of each phase.
  task automatic do_edge(input int src, input int dst);
    coo_src = NODE_BW'(src);
    coo_dst = NODE_BW'(dst);
    idle();
    read_fm_wm_adj = 1'b1;
    #1 check("addr_phase1", 64'(fm_wm_addr), 64'(src));
    tick();
    enable_write_fm_wm_adj_prod = 1'b1;
    fm_wm_row = rows[src];
    tick();
    idle();
    read_fm_wm = 1'b1;
    #1 check("addr_phase2", 64'(fm_wm_addr), 64'(dst));
    tick();
    enable_write_fm_wm_adj_prod = 1'b1;
    fm_wm_row = rows[dst];
    tick();
    idle();
    enable_edge_counter = 1'b1;
    tick();
    idle();
  endtask

  typedef struct packed {
    logic [1:0]            src;
    logic [1:0]            dst;
    logic [COO_BW-1:0]     cnt;
    logic [2:0][AW-1:0]    acc;
  } edge_vec_t;

  edge_vec_t vec [COO_EDGES];

  initial begin
    rows[0] = row3(1, 2, 3);
    rows[1] = row3(10, 20, 30);
    rows[2] = row3(5, -5, 7);

    vec[0] = '{src: 2'd0, dst: 2'd1, cnt: 3'd1,
               acc: {acc3(0, 0, 0),    acc3(1, 2, 3),  acc3(10, 20, 30)}};
    vec[1] = '{src: 2'd2, dst: 2'd2, cnt: 3'd2,
               acc: {acc3(5, -5, 7),   acc3(1, 2, 3),  acc3(10, 20, 30)}};
    vec[2] = '{src: 2'd1, dst: 2'd2, cnt: 3'd3,
               acc: {acc3(15, 15, 37), acc3(6, -3, 10), acc3(10, 20, 30)}};
    vec[3] = '{src: 2'd0, dst: 2'd2, cnt: 3'd4,
               acc: {acc3(16, 17, 40), acc3(6, -3, 10), acc3(15, 15, 37)}};
    vec[4] = '{src: 2'd1, dst: 2'd0, cnt: 3'd5,
               acc: {acc3(16, 17, 40), acc3(7, -1, 13), acc3(25, 35, 67)}};
    vec[5] = '{src: 2'd0, dst: 2'd0, cnt: 3'd0,
               acc: {acc3(16, 17, 40), acc3(7, -1, 13), acc3(26, 37, 70)}};

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    check("reset_count", 64'(edge_count), 64'd0);
    check("reset_err", 64'(protocol_err), 64'd0);
    check("reset_rd", 64'(rd_data), 64'd0);
    reset = 1'b1;
    check("idle_addr", 64'(fm_wm_addr), 64'd0);
    for (int n = 0; n <= NODES; n++)
      read_check($sformatf("reset_node%0d", n), n, '0);

    // Edge table: cumulative accumulators after each full edge
    for (int i = 0; i < COO_EDGES; i++) begin
      do_edge(int'(vec[i].src), int'(vec[i].dst));
      check($sformatf("edge%0d_count", i), 64'(edge_count), 64'(vec[i].cnt));
      for (int n = 0; n < NODES; n++)
        read_check($sformatf("edge%0d_node%0d", i, n), n, vec[i].acc[n]);
    end
    check("table_err", 64'(protocol_err), 64'd0);
    read_check("oob_readback", 3, '0);

    // Clear, then saturation into node 1 via repeated phase-1 writes
    do_clear();
    check("clear_count", 64'(edge_count), 64'd0);
    read_check("clear_node0", 0, '0);
    coo_src = 2'd0;
    coo_dst = 2'd1;
    fm_wm_row = row3(32767, -32768, 1);
    rd_node = 2'd1;
    read_fm_wm_adj = 1'b1;
    enable_write_fm_wm_adj_prod = 1'b1;
    tick();
    check("prewrite_read", 64'(rd_data), 64'd0);
    check("visible_after_1", 64'(rd_data), 64'(acc3(0, 0, 0)));
    tick();
    check("visible_after_2", 64'(rd_data), 64'(acc3(32767, -32768, 1)));
    repeat (18) tick();
    read_check("sat_node1", 1, acc3(524287, -524288, 20));
    check("sat_err", 64'(protocol_err), 64'd0);

    // Both read strobes with write: error, nothing written
    do_clear();
    coo_src = 2'd0;
    coo_dst = 2'd2;
    fm_wm_row = rows[1];
    read_fm_wm_adj = 1'b1;
    read_fm_wm = 1'b1;
    enable_write_fm_wm_adj_prod = 1'b1;
    tick();
    check("both_strobe_err", 64'(protocol_err), 64'd1);
    read_check("both_node2", 2, '0);
    read_check("both_node0", 0, '0);
    check("err_sticky", 64'(protocol_err), 64'd1);

    // Out-of-range destination
    do_clear();
    check("clear_err", 64'(protocol_err), 64'd0);
    coo_src = 2'd1;
    coo_dst = 2'd3;
    fm_wm_row = rows[0];
    read_fm_wm_adj = 1'b1;
    enable_write_fm_wm_adj_prod = 1'b1;
    tick();
    check("oob_err", 64'(protocol_err), 64'd1);
    for (int n = 0; n < NODES; n++)
      read_check($sformatf("oob_node%0d", n), n, '0);

    // Write with no read strobe
    do_clear();
    coo_dst = 2'd1;
    enable_write_fm_wm_adj_prod = 1'b1;
    tick();
    check("write_only_err", 64'(protocol_err), 64'd1);
    read_check("write_only_node1", 1, '0);

    // Counter advance together with a strobe
    do_clear();
    read_fm_wm = 1'b1;
    enable_edge_counter = 1'b1;
    tick();
    check("cnt_strobe_err", 64'(protocol_err), 64'd1);

    // Clear wins over a write in the same cycle
    do_clear();
    coo_src = 2'd0;
    coo_dst = 2'd1;
    fm_wm_row = rows[2];
    read_fm_wm_adj = 1'b1;
    enable_write_fm_wm_adj_prod = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    read_check("clear_prio_node1", 1, '0);

    // Reset mid-edge aborts and leaves nothing behind
    do_edge(0, 1);
    coo_src = 2'd1;
    coo_dst = 2'd2;
    read_fm_wm_adj = 1'b1;
    tick();
    enable_write_fm_wm_adj_prod = 1'b1;
    fm_wm_row = rows[1];
    tick();
    idle();
    read_fm_wm = 1'b1;
    #2 reset = 1'b0;
    #1;
    check("midreset_count", 64'(edge_count), 64'd0);
    check("midreset_rd", 64'(rd_data), 64'd0);
    check("midreset_err", 64'(protocol_err), 64'd0);
    idle();
    tick();
    reset = 1'b1;
    for (int n = 0; n < NODES; n++)
      read_check($sformatf("midreset_node%0d", n), n, '0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule

// File: doc/gcn_edge_aggregator.md
# gcn_edge_aggregator

Datapath responder for the GCN edge-traversal controller. It owns the COO edge counter, steers the feature×weight (FM·W) row address from the current COO edge, and accumulates fetched FM·W rows into an on-chip adjacency-product (A·FM·W) memory. Aggregation is undirected: row[src] is added into node dst, then row[dst] into node src. The block sits between the controller's strobes, the external COO ROM and FM·W memory, and the next GCN layer, which reads results through a registered read port.

## Interface
- COO_EDGES, 6, number of edges in the COO list
- COO_BW, $clog2(COO_EDGES), edge counter width
- NODES, 4, graph node count
- NODE_BW, $clog2(NODES), node index width
- FEATURES, 3, output features per node
- DATA_W, 16, signed FM·W element width
- ACC_W, 20, signed accumulator width (≥ DATA_W)

- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear of the edge counter, accumulators and error flag
- read_fm_wm_adj  in  1  phase 1 strobe: address = src, target = dst
- read_fm_wm  in  1  phase 2 strobe: address = dst, target = src
- enable_write_fm_wm_adj_prod  in  1  accumulate the current row into the target node
- enable_edge_counter  in  1  advance to the next edge
- coo_src  in  NODE_BW  source node of edge edge_count, from combinational COO ROM
- coo_dst  in  NODE_BW  destination node of edge edge_count
- fm_wm_row  in  FEATURES*DATA_W  FM·W row, element f at [f*DATA_W +: DATA_W], valid one cycle after fm_wm_addr
- rd_node  in  NODE_BW  readback node index
- edge_count  out  COO_BW  current edge index, registered
- fm_wm_addr  out  NODE_BW  FM·W row address, combinational
- rd_data  out  FEATURES*ACC_W  accumulated row of rd_node, registered
- protocol_err  out  1  sticky protocol/range error

## Operation
- The one clock is clk. reset is asynchronous and active-low.
- Asynchronous reset (reset=0) sets edge_count, rd_data and protocol_err to 0 and zeroes all NODES×FEATURES accumulators.
- clear=1 does the same synchronously in one cycle. clear has priority over every strobe in that cycle.
- fm_wm_addr = coo_src when read_fm_wm_adj=1; coo_dst when read_fm_wm=1; 0 when neither is asserted.
- Accumulate happens on a rising edge with enable_write_fm_wm_adj_prod=1 and exactly one read strobe asserted:
  - target = coo_dst in phase 1, coo_src in phase 2.
  - acc[target][f] ← sat(acc[target][f] + sext(fm_wm_row[f])) for all f in parallel.
  - sat clamps to [−2^(ACC_W−1), 2^(ACC_W−1)−1].
- Self-loop (coo_src == coo_dst): the phase-2 write is suppressed, so the row is added once. The phase-1 write proceeds.
- Out-of-range index (target ≥ NODES): the write is suppressed and protocol_err is set.
- protocol_err is also set by:
  - both read strobes high in the same cycle
  - write high with no read strobe
  - enable_edge_counter high together with any read or write strobe
- In any erroring cycle no accumulator changes. protocol_err clears only on reset or clear.
- enable_edge_counter=1: edge_count increments, wrapping from COO_EDGES−1 to 0.
- Readback: rd_data ← acc[rd_node] each cycle. rd_node ≥ NODES returns 0.

## Timing
- fm_wm_addr is combinational from the strobes and COO inputs.
- External FM·W memory has 1-cycle read latency. The row addressed during the first cycle of a phase (write=0) is consumed in the second cycle of that phase (write=1).
- A strobe pair occupies 2 cycles; one full edge takes 5 controller cycles.
- An accumulator update is visible in rd_data 2 cycles after the write edge: one cycle for the write, one for the readback register.
- Reading and writing the same node in one cycle returns the pre-write value.
- edge_count changes on the edge that samples enable_edge_counter. The COO inputs must settle before the next phase-1 cycle.
- Reset asserted mid-edge aborts it immediately. No partial accumulation survives.

## Test plan
- Reset then idle: all rd_node values → rd_data = 0, edge_count = 0, protocol_err = 0.
- Edge (0,1), rows r0 = {1,2,3}, r1 = {10,20,30}, full 5-cycle sequence → acc[1] = {1,2,3}, acc[0] = {10,20,30}, edge_count = 1.
- Self-loop edge (2,2) with r2 = {5,−5,7} → acc[2] = {5,−5,7}, not doubled.
- Six edges traversed → edge_count wraps 5 → 0. Accumulators match a software A·FM·W with symmetric adjacency.
- Repeated adds of 0x7FFF into one node until overflow → clamps at 2^19−1. Negative rows clamp at −2^19.
- Both read strobes together with write, then an out-of-range coo_dst = NODES → protocol_err = 1, accumulators unchanged, err sticky until clear.
